// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM receive path.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_shift_reg.sv
// Per-channel MSB-first word assembler: shifts left and takes the new bit at the LSB.
module tdm_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base;

  // Clear and shift may coincide: the register restarts with bit_in as its first bit.
  always_comb begin
    base = clear ? '0 : q_q;
    q_d  = base;
    if (shift_en) q_d = {base[WIDTH-2:0], bit_in};
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule : tdm_shift_reg

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: locks to frame sync, steers bits to channel
// shift registers and publishes all four words with a one-cycle valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic               din,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic               locked,
  output logic               sync_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);

  tdm_state_t          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [4*WIDTH-1:0]  dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_err_q, sync_err_d;

  logic [NCH-1:0]      shift_en;
  logic                clear;
  logic [WIDTH-1:0]    ch_q [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tdm_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en[k]),
      .clear    (clear),
      .bit_in   (din),
      .q        (ch_q[k])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    shift_en     = '0;
    clear        = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            clear       = 1'b1;
            shift_en[0] = 1'b1;
            slot_d      = SLOT_W'(1);
            bit_cnt_d   = '0;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && slot_q != '0) begin
            // Early sync: drop the partial word and restart on this bit.
            sync_err_d  = 1'b1;
            clear       = 1'b1;
            shift_en[0] = 1'b1;
            slot_d      = SLOT_W'(1);
            bit_cnt_d   = '0;
          end else if (!frame_sync && slot_q == '0) begin
            sync_err_d  = 1'b1;
            clear       = 1'b1;
            slot_d      = '0;
            bit_cnt_d   = '0;
            state_d     = HUNT;
          end else begin
            shift_en[slot_q] = 1'b1;
            slot_d           = slot_q + 1'b1;
            if (slot_q == LAST_SLOT) begin
              bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
                // Channel 3 still lacks the bit being accepted now.
                for (int k = 0; k < NCH - 1; k++) dout_d[WIDTH*k +: WIDTH] = ch_q[k];
                dout_d[WIDTH*(NCH-1) +: WIDTH] = {ch_q[NCH-1][WIDTH-2:0], din};
                dout_valid_d = 1'b1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WIDTH=8): lock, gaps, early/missing sync, reset mid-word.
module tb_tdm_demux4;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               frame_sync = 1'b0;
  logic [4*WIDTH-1:0] dout;
  logic               dout_valid;
  logic               locked;
  logic               sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  int          acc_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] pulse_dout[$];
  int          pulse_acc[$];

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && din_valid) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) begin
    if (dout_valid) begin
      pulse_dout.push_back(dout);
      pulse_acc.push_back(acc_cnt);
    end
    if (sync_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the edge that accepted the bit.
  task automatic send_bit(input logic b, input logic fs, input int gap);
    repeat (gap) realign();
    din_valid  = 1'b1;
    din        = b;
    frame_sync = fs;
    realign();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  // Sends bits [first, last] of a word in wire order; bit i is frame i/4, slot i%4.
  task automatic send_range(input logic [31:0] w, input int first, input int last,
                            input int max_gap);
    for (int i = first; i <= last; i++) begin
      int slot;
      int bpos;
      slot = i % 4;
      bpos = WIDTH - 1 - i / 4;
      send_bit(w[WIDTH*slot + bpos], slot == 0, $urandom_range(0, max_gap));
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w);
    @(negedge clk);
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_dout"}, dout, w);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
    realign();
  endtask

  initial begin
    int p0, e0, a0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 32'h0);
    check("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;
    realign();
    check("post_rst_dout", dout, 32'h0);
    check("post_rst_valid", 32'(dout_valid), 32'd0);
    check("post_rst_locked", 32'(locked), 32'd0);
    check("post_rst_err", 32'(sync_err), 32'd0);

    // 2: junk bits, then a clean word
    p0 = pulse_dout.size();
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 0);
    check("hunt_locked", 32'(locked), 32'd0);
    send_range(32'h00FF3CA5, 0, 0, 0);
    @(negedge clk);
    check("lock_after_sync", 32'(locked), 32'd1);
    realign();
    send_range(32'h00FF3CA5, 1, 31, 0);
    expect_word("w1", 32'h00FF3CA5);
    check("w1_pulses", 32'(pulse_dout.size() - p0), 32'd1);
    check("w1_errs", 32'(err_cnt), 32'd0);

    // 3: same word with din_valid gaps
    p0 = pulse_dout.size();
    send_range(32'h00FF3CA5, 0, 31, 3);
    expect_word("w2_gaps", 32'h00FF3CA5);
    check("w2_pulses", 32'(pulse_dout.size() - p0), 32'd1);

    // 4: early sync on slot 2, restart with a clean word from that bit
    p0 = pulse_dout.size();
    e0 = err_cnt;
    send_range(32'hAAAAAAAA, 0, 9, 0);
    send_range(32'h12345678, 0, 0, 0);
    @(negedge clk);
    check("early_err_pulse", 32'(sync_err), 32'd1);
    check("early_locked", 32'(locked), 32'd1);
    realign();
    send_range(32'h12345678, 1, 31, 0);
    expect_word("w3", 32'h12345678);
    check("early_errs", 32'(err_cnt - e0), 32'd1);
    check("early_pulses", 32'(pulse_dout.size() - p0), 32'd1);

    // 5: missing sync on slot 0 of frame 4
    p0 = pulse_dout.size();
    e0 = err_cnt;
    send_range(32'h55555555, 0, 15, 0);
    send_bit(1'b1, 1'b0, 0);
    @(negedge clk);
    check("miss_err_pulse", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    realign();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 0);
    check("miss_ignored_locked", 32'(locked), 32'd0);
    send_range(32'h0BADCAFE, 0, 31, 1);
    expect_word("w4", 32'h0BADCAFE);
    check("miss_errs", 32'(err_cnt - e0), 32'd1);
    check("miss_pulses", 32'(pulse_dout.size() - p0), 32'd1);

    // 6: reset after 17 bits, then two back-to-back words
    send_range(32'h99999999, 0, 16, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 32'h0);
    check("midrst_locked", 32'(locked), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    realign();
    p0 = pulse_dout.size();
    a0 = acc_cnt;
    send_range(32'h11223344, 0, 31, 0);
    send_range(32'hDEADBEEF, 0, 31, 0);
    repeat (3) realign();
    check("b2b_pulses", 32'(pulse_dout.size() - p0), 32'd2);
    if (pulse_dout.size() - p0 >= 2) begin
      check("b2b_w1", pulse_dout[p0], 32'h11223344);
      check("b2b_w2", pulse_dout[p0+1], 32'hDEADBEEF);
      check("b2b_acc1", 32'(pulse_acc[p0] - a0), 32'd32);
      check("b2b_spacing", 32'(pulse_acc[p0+1] - pulse_acc[p0]), 32'd32);
    end
    check("b2b_dout_hold", dout, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tdm_demux4

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the team's 4-to-1 time-division link. A 4-input mux serialises one bit per channel per frame onto a single line; this block splits that line back out.
- Locks to a frame-sync marker and steers each accepted serial bit to its channel slot.
- Assembles one WIDTH-bit word per channel and presents all four words together with a one-cycle valid pulse.
- Sits between the serial link input and the per-channel consumers.

Parameters:
- WIDTH, 8, bits per channel word (legal range 2 to 32).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_valid  input  1  din and frame_sync are sampled only when this is high.
- din  input  1  serial data bit.
- frame_sync  input  1  marks the slot-0 bit of each 4-bit frame; qualified by din_valid.
- dout  output  4*WIDTH  assembled words; dout[WIDTH*k +: WIDTH] is channel k.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, dout_valid=0, locked=0, sync_err=0, shift registers=0, slot=0, bit_cnt=0, state=HUNT.
- An accepted bit is din_valid=1 on a rising clk edge. When din_valid=0, all state holds and the pulse outputs are 0.
- Frame format:
  - A frame is 4 accepted bits, in slot order 0, 1, 2, 3.
  - A word is WIDTH consecutive frames, giving 4*WIDTH accepted bits.
  - Each channel word is sent MSB first. The channel shift register shifts left and takes the new bit at the LSB.
- State HUNT:
  - Accepted bits without frame_sync are discarded.
  - An accepted bit with frame_sync=1 is taken as slot 0, bit 0: it goes into ch0's shift register, then slot=1, bit_cnt=0, state goes to LOCKED, and locked=1 from the next cycle.
- State LOCKED, per accepted bit:
  - The bit is shifted into the register of channel[slot].
  - slot increments modulo 4.
  - When slot wraps from 3 to 0, bit_cnt increments modulo WIDTH.
- Word completion:
  - Triggered by an accepted bit with slot=3 and bit_cnt=WIDTH-1.
  - dout loads all four words, including the current bit.
  - dout_valid is high in the following cycle only. Latency is one cycle from the last accepted bit to dout_valid.
  - dout holds its value until the next completion.
  - The next accepted bit starts a new word. Back-to-back words have no gap.
- Framing rules in LOCKED (frame_sync is evaluated only on accepted bits):
  - frame_sync=1 with slot≠0 (early sync):
    - sync_err pulses in the next cycle.
    - The partial word is discarded: shift registers are cleared and no dout_valid is generated.
    - The current bit is re-taken as slot 0, bit 0, so slot=1 and bit_cnt=0.
    - State stays LOCKED.
  - frame_sync=0 with slot=0 (missing sync):
    - sync_err pulses in the next cycle.
    - The bit is discarded and the partial word is cleared.
    - State goes to HUNT and locked=0 from the next cycle.
  - frame_sync=1 with slot=0: normal; no error.
- Simultaneous events: completion cannot coincide with a sync error, because completion is at slot 3 and a missing-sync error is at slot 0. An early sync at slot 3 is an error, not a completion.
- Reset mid-word: everything is cleared at once, and the partial word is never output.

Decomposition:
- Shared package tdm_pkg:
  - localparam NCH=4 and SLOT_W=2.
  - Enum tdm_state_t with values HUNT and LOCKED.
- Sub-module tdm_shift_reg (parameter WIDTH; ports clk, rst_n, shift_en, clear, bit_in, q), instantiated NCH times.
- Top level holds the state machine, slot and bit_cnt counters, the dout register, and the pulse outputs.

Test Plan (WIDTH=8):
1. Assert reset for 3 cycles, then release -> dout=0, dout_valid=0, locked=0, sync_err=0.
2. Send 5 accepted bits without frame_sync, then a clean word with ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x00 -> dout=0x00FF3CA5, a single dout_valid pulse one cycle after the 32nd bit, locked=1 from the cycle after the first sync bit.
3. Repeat scenario 2 with random din_valid=0 gaps of 0 to 3 cycles between bits -> identical dout and a single pulse.
4. Mid-word, assert frame_sync on a slot-2 bit, then send a clean word from that bit with ch0=0x78, ch1=0x56, ch2=0x34, ch3=0x12 -> one sync_err pulse, no pulse for the aborted word, then dout=0x12345678.
5. Drop frame_sync on the slot-0 bit of frame 4 -> sync_err pulse, locked=0; following bits ignored until the next frame_sync; the subsequent clean word is output correctly.
6. Assert rst_n low after 17 bits of a word, then run two back-to-back words (0x11223344, 0xDEADBEEF) -> immediate clear, then dout_valid pulses exactly 32 accepted bits apart with the matching dout values.
